// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counts for the decode stage.
// Drives stall/issue/bubble from operand and destination busy state.
module hazard_scoreboard #(
  parameter bit ZERO_REG_HARDWIRED = 1'b1,
  parameter bit RF_WRITE_FIRST = 1'b1,
  parameter int MAX_PENDING = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ID_Valid,
  input  logic [15:0] i_Instruction,
  input  logic        i_Sig_RegDst,
  input  logic        i_Sig_ALUSrc,
  input  logic        i_Sig_RegWrite,
  input  logic        i_Sig_MemWrite,
  input  logic        i_Sig_Branch,
  input  logic        i_Flush,
  input  logic        i_WB_RegWrite,
  input  logic [2:0]  i_WB_Write_Register,
  input  logic        i_Kill_Valid,
  input  logic [2:0]  i_Kill_Register,
  output logic        o_Stall,
  output logic        o_Issue,
  output logic        o_Bubble,
  output logic [7:0]  o_Busy_Mask,
  output logic        o_Error
);

  logic [1:0] cnt [8];
  logic [1:0] cnt_nxt [8];
  logic [7:0] busy;
  logic [7:0] under;
  logic [2:0] rs, rt, rd, dst;
  logic       rt_used;
  logic       hazard, full;
  logic       unused_bits;

  assign rs = i_Instruction[12:10];
  assign rt = i_Instruction[9:7];
  assign rd = i_Instruction[6:4];
  assign dst = i_Sig_RegDst ? rd : rt;
  assign rt_used = !i_Sig_ALUSrc | i_Sig_MemWrite | i_Sig_Branch;
  assign unused_bits = ^{i_Instruction[15:13], i_Instruction[3:0]};

  // Busy per register; a retiring last write no longer blocks readers.
  always_comb begin
    busy = '0;
    for (int r = 0; r < 8; r++) begin
      logic ret;
      ret = (i_WB_RegWrite && i_WB_Write_Register == 3'(r)) ||
            (i_Kill_Valid && i_Kill_Register == 3'(r));
      busy[r] = (cnt[r] != 2'd0) &&
                !(RF_WRITE_FIRST && cnt[r] == 2'd1 && ret);
    end
    if (ZERO_REG_HARDWIRED) busy[0] = 1'b0;
  end

  // Issue decision: source hazards and destination saturation.
  always_comb begin
    hazard = busy[rs] | (rt_used & busy[rt]);
    full = i_Sig_RegWrite && (cnt[dst] == 2'(MAX_PENDING));
    o_Issue = !rst & i_ID_Valid & !i_Flush & !hazard & !full;
    o_Stall = !rst & i_ID_Valid & !i_Flush & (hazard | full);
    o_Bubble = !o_Issue;
  end

  // Next counts: increment on issue, decrement on retire and kill.
  always_comb begin
    under = '0;
    for (int r = 0; r < 8; r++) begin
      logic [2:0] sum;
      logic [2:0] dec;
      sum = {1'b0, cnt[r]} +
            {2'b0, o_Issue & i_Sig_RegWrite & (dst == 3'(r))};
      dec = {2'b0, i_WB_RegWrite & (i_WB_Write_Register == 3'(r))} +
            {2'b0, i_Kill_Valid & (i_Kill_Register == 3'(r))};
      if (sum < dec) begin
        cnt_nxt[r] = 2'd0;
        under[r] = 1'b1;
      end else begin
        cnt_nxt[r] = 2'(sum - dec);
      end
    end
    if (ZERO_REG_HARDWIRED) begin
      cnt_nxt[0] = 2'd0;
      under[0] = 1'b0;
    end
  end

  // Count, busy mask and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 8; r++) cnt[r] <= 2'd0;
      o_Busy_Mask <= 8'h00;
      o_Error <= 1'b0;
    end else begin
      for (int r = 0; r < 8; r++) begin
        cnt[r] <= cnt_nxt[r];
        o_Busy_Mask[r] <= (cnt_nxt[r] != 2'd0);
      end
      o_Error <= o_Error | (|under);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-dependency controller for the decode stage of the 16-bit, 8-register pipelined core. It keeps a pending-write count for each architectural register. It stalls the instruction in ID while any source operand it reads, or its saturated destination, has a write still in flight. It tells the pipeline when to issue into ID/EX and when to insert a bubble. Write-back retirements and squashes of in-flight instructions decrement the counts.

## Interface
- ZERO_REG_HARDWIRED, 1, register 0 is never marked busy, never stalls, and its retirements are ignored
- RF_WRITE_FIRST, 1, register file writes before reads in a cycle, so a retiring write clears the hazard in the same cycle
- MAX_PENDING, 3, maximum in-flight writes per register; counter width is 2 bits
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_ID_Valid  in  1  ID holds a valid instruction
- i_Instruction  in  16  ID instruction: rs=[12:10], rt=[9:7], rd=[6:4]
- i_Sig_RegDst, i_Sig_ALUSrc, i_Sig_RegWrite, i_Sig_MemWrite, i_Sig_Branch  in  1 each  control-unit decode of the ID instruction
- i_Flush  in  1  squash the ID instruction this cycle
- i_WB_RegWrite  in  1  register file write this cycle
- i_WB_Write_Register  in  3  register being written
- i_Kill_Valid  in  1  an issued RegWrite instruction was squashed and will never write back
- i_Kill_Register  in  3  destination of the squashed instruction
- o_Stall  out  1  hold PC and IF/ID
- o_Issue  out  1  ID instruction advances into ID/EX
- o_Bubble  out  1  load a NOP into ID/EX
- o_Busy_Mask  out  8  registered; bit r = count[r]!=0
- o_Error  out  1  sticky; a decrement was applied to a count of 0

## Operation
- Destination: dst = rd when i_Sig_RegDst, otherwise rt.
- Source use: rs is always read. rt is read when !i_Sig_ALUSrc, i_Sig_MemWrite, or i_Sig_Branch.
- busy(r) = count[r]!=0.
  - If RF_WRITE_FIRST, busy excludes the case count[r]==1 with a retire or kill of r this cycle.
  - If ZERO_REG_HARDWIRED, busy(0)=0.
- hazard = (busy(rs)) OR (rt used AND busy(rt)).
- full = i_Sig_RegWrite AND count[dst]==MAX_PENDING, evaluated before decrements.
- Combinational outputs:
  - o_Issue = !rst & i_ID_Valid & !i_Flush & !hazard & !full
  - o_Stall = !rst & i_ID_Valid & !i_Flush & (hazard | full)
  - o_Bubble = !o_Issue
- Count update, per register r: count[r] <= count[r] + inc - dwb - dkill, where:
  - inc = o_Issue & i_Sig_RegWrite & dst==r
  - dwb = i_WB_RegWrite & i_WB_Write_Register==r
  - dkill = i_Kill_Valid & i_Kill_Register==r
- Simultaneous events:
  - Retire and kill of the same r: decrement by 2.
  - Inc, retire and kill of the same r all apply together (net change -1).
- Underflow: if the result would go below 0, clamp to 0 and set o_Error. o_Error is cleared only by rst.
- With ZERO_REG_HARDWIRED, count[0] stays 0 and events on r0 never set o_Error.
- Overflow cannot occur, because full stalls issue.
- i_Flush has priority: the squashed ID instruction neither issues nor stalls, and leaves no state.

## Timing
- Reset: all counts = 0, o_Busy_Mask = 8'h00, o_Error = 0.
- While rst is high: o_Issue = 0, o_Stall = 0, o_Bubble = 1.
- Reset asserted mid-operation discards all pending counts on that edge.
- o_Stall, o_Issue and o_Bubble are combinational from the inputs and the current counts, with zero cycle latency.
- Counts and o_Busy_Mask update one edge after the triggering event.
- A dependent instruction presented in the cycle after its producer issues sees busy=1.
- Throughput: one issue per cycle when there is no hazard.
- While stalled, i_Instruction is held stable by the upstream stage.
- The stall is re-evaluated every cycle.

## Test plan
- Independent stream: after reset, issue writes to r1, r2, r3 on consecutive cycles, then read only r4 and r5.
  - o_Stall=0 throughout.
  - o_Busy_Mask=8'h0E after the third edge.
- RAW stall:
  - Issue a write to r2, then present rs=r2.
  - o_Stall=1 and o_Bubble=1 until the cycle of i_WB_RegWrite to r2. With RF_WRITE_FIRST, o_Issue=1 in that same cycle.
- Unused rt:
  - r3 is busy; present rt=r3 with ALUSrc=1, MemWrite=0, Branch=0 → o_Issue=1.
  - The same operands with MemWrite=1 → o_Stall=1.
- Saturation: issue 3 writes to r5, then a 4th write to r5 with rs=r0.
  - o_Stall=1.
  - After one retire of r5, o_Issue=1; count[r5] stays 3.
- Kill and simultaneous events:
  - count[r6]=2; retire r6 and kill r6 in the same cycle → bit 6 of o_Busy_Mask =0, o_Error=0.
  - A further kill of r6 → o_Error=1.
- Flush and reset:
  - i_Flush with a hazard present → o_Stall=0, o_Issue=0, no count change.
  - rst with o_Busy_Mask=8'hFE → o_Busy_Mask=8'h00 next edge, o_Error=0.
